// File: rtl/morph_pkg.sv
// Shared definitions for the 3x3 binary morphology frame sequencer:
// kernel mode encodings, sequencer states and default frame geometry.
package morph_pkg;

    localparam logic [1:0] MODE_BYPASS = 2'b00;
    localparam logic [1:0] MODE_DILATE = 2'b01;
    localparam logic [1:0] MODE_ERODE  = 2'b10;

    localparam int DEF_IMG_W = 320;
    localparam int DEF_IMG_H = 240;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_PRIME,
        ST_RUN,
        ST_FLUSH,
        ST_DONE
    } state_t;

    // The unused encoding 11 falls back to bypass so the kernel never sees it.
    function automatic logic [1:0] kern_op_of(input logic [1:0] mode);
        case (mode)
            MODE_DILATE: return MODE_DILATE;
            MODE_ERODE:  return MODE_ERODE;
            default:     return MODE_BYPASS;
        endcase
    endfunction

endpackage

// File: rtl/morph_pos_cnt.sv
// Raster-order x/y position counter: x wraps at IMG_W-1 and carries into y,
// y wraps at IMG_H-1. Clear has priority over enable.
module morph_pos_cnt #(
    parameter int IMG_W = 320,
    parameter int IMG_H = 240,
    parameter int XW    = 10,
    parameter int YW    = 9
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          clr,
    input  logic          en,
    output logic [XW-1:0] x,
    output logic [YW-1:0] y
);

    localparam logic [XW-1:0] X_LAST = XW'(IMG_W - 1);
    localparam logic [YW-1:0] Y_LAST = YW'(IMG_H - 1);

    // Advance one raster position per enable, restarting at (0,0) on clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            x <= '0;
            y <= '0;
        end else if (clr) begin
            x <= '0;
            y <= '0;
        end else if (en) begin
            if (x == X_LAST) begin
                x <= '0;
                y <= (y == Y_LAST) ? '0 : y + 1'b1;
            end else begin
                x <= x + 1'b1;
            end
        end
    end

endmodule

// File: rtl/morph_frame_seq.sv
// Frame sequencer for the 3x3 binary morphology stage. Primes the line
// buffer with IMG_W+1 pixels, then emits one window centre per accepted
// pixel, and finally flushes the window with zero-fed shifts so every input
// pixel yields exactly one centre per frame.
module morph_frame_seq
    import morph_pkg::*;
#(
    parameter int IMG_W = DEF_IMG_W,
    parameter int IMG_H = DEF_IMG_H,
    parameter int XW    = 10,
    parameter int YW    = 9,
    parameter int NW    = 17
) (
    input  logic          iclk,
    input  logic          irst_n,
    input  logic          iFVAL,
    input  logic          iDVAL,
    input  logic [1:0]    iMODE,
    output logic          oSHIFT_EN,
    output logic          oFEED_ZERO,
    output logic [1:0]    oKERN_OP,
    output logic          oCEN_VAL,
    output logic [XW-1:0] oX,
    output logic [YW-1:0] oY,
    output logic          oBORDER,
    output logic          oFRAME_DONE,
    output logic          oERR,
    output logic          oBUSY
);

    localparam int N  = IMG_W * IMG_H;
    localparam int P  = IMG_W + 1;
    // Tiny frames never leave PRIME, so the flush alone must produce all N centres.
    localparam int FL = (N < P) ? N : P;
    localparam int FW = XW + 1;

    localparam logic [NW-1:0] N_LAST  = NW'(N - 1);
    localparam logic [NW-1:0] P_LAST  = NW'(P - 1);
    localparam logic [FW-1:0] FL_LAST = FW'(FL - 1);
    localparam logic [XW-1:0] X_LAST  = XW'(IMG_W - 1);
    localparam logic [YW-1:0] Y_LAST  = YW'(IMG_H - 1);

    state_t        state;
    logic          fval_q;
    logic [NW-1:0] in_cnt;
    logic [FW-1:0] fl_cnt;

    logic          rise;
    logic          start;
    logic          accept;
    logic          complete;
    logic          border;
    logic [XW-1:0] pos_x;
    logic [YW-1:0] pos_y;

    // Pixel acceptance and window completion. The frame-start cycle accepts
    // its pixel too, so that pixel is shifted into the line buffer as pixel 0.
    always_comb begin
        rise     = iFVAL & ~fval_q;
        start    = (state == ST_IDLE) & rise;
        accept   = iFVAL & iDVAL &
                   ((state == ST_PRIME) | (state == ST_RUN) | start);
        complete = ((state == ST_RUN) & accept) | (state == ST_FLUSH);
        border   = (pos_x == '0) | (pos_x == X_LAST) |
                   (pos_y == '0) | (pos_y == Y_LAST);
    end

    assign oSHIFT_EN  = accept | (state == ST_FLUSH);
    assign oFEED_ZERO = (state == ST_FLUSH);
    assign oBUSY      = (state == ST_PRIME) | (state == ST_RUN) | (state == ST_FLUSH);

    morph_pos_cnt #(
        .IMG_W (IMG_W),
        .IMG_H (IMG_H),
        .XW    (XW),
        .YW    (YW)
    ) u_pos (
        .clk   (iclk),
        .rst_n (irst_n),
        .clr   (start),
        .en    (complete),
        .x     (pos_x),
        .y     (pos_y)
    );

    // Frame state machine with registered centre, border, done and error outputs.
    always_ff @(posedge iclk or negedge irst_n) begin
        if (!irst_n) begin
            state       <= ST_IDLE;
            fval_q      <= 1'b0;
            in_cnt      <= '0;
            fl_cnt      <= '0;
            oKERN_OP    <= MODE_BYPASS;
            oCEN_VAL    <= 1'b0;
            oX          <= '0;
            oY          <= '0;
            oBORDER     <= 1'b0;
            oFRAME_DONE <= 1'b0;
            oERR        <= 1'b0;
        end else begin
            fval_q      <= iFVAL;
            oCEN_VAL    <= complete;
            oBORDER     <= complete & border;
            // The final centre is presented during the first DONE cycle.
            oFRAME_DONE <= (state == ST_DONE) & oCEN_VAL;
            oERR        <= 1'b0;
            if (complete) begin
                oX <= pos_x;
                oY <= pos_y;
            end

            case (state)
                ST_IDLE: begin
                    if (rise) begin
                        oKERN_OP <= kern_op_of(iMODE);
                        in_cnt   <= {{(NW-1){1'b0}}, iDVAL};
                        fl_cnt   <= '0;
                        state    <= ST_PRIME;
                    end
                end
                ST_PRIME: begin
                    if (!iFVAL) begin
                        oERR  <= 1'b1;
                        state <= ST_IDLE;
                    end else if (accept) begin
                        in_cnt <= in_cnt + 1'b1;
                        if (in_cnt == N_LAST)
                            state <= ST_FLUSH;
                        else if (in_cnt == P_LAST)
                            state <= ST_RUN;
                    end
                end
                ST_RUN: begin
                    if (!iFVAL) begin
                        oERR  <= 1'b1;
                        state <= ST_IDLE;
                    end else if (accept) begin
                        in_cnt <= in_cnt + 1'b1;
                        if (in_cnt == N_LAST)
                            state <= ST_FLUSH;
                    end
                end
                ST_FLUSH: begin
                    // Stray pixels are dropped; the flush keeps its own pace.
                    if (iFVAL & iDVAL)
                        oERR <= 1'b1;
                    fl_cnt <= fl_cnt + 1'b1;
                    if (fl_cnt == FL_LAST)
                        state <= ST_DONE;
                end
                ST_DONE: begin
                    if (!iFVAL)
                        state <= ST_IDLE;
                    else if (iDVAL)
                        oERR <= 1'b1;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_morph_frame_seq.sv
// Self-checking bench for morph_frame_seq on an 8x4 frame. A cycle model
// built from frame-level rules (pixel count, shift index, output index =
// shift index - priming depth) predicts every output each cycle; per-frame
// totals are compared against closed-form constants.
module tb_morph_frame_seq;

    localparam int W  = 8;
    localparam int H  = 4;
    localparam int N  = W * H;
    localparam int P  = W + 1;
    localparam int XW = 10;
    localparam int YW = 9;
    localparam int NW = 17;

    logic          iclk;
    logic          irst_n;
    logic          iFVAL;
    logic          iDVAL;
    logic [1:0]    iMODE;
    logic          oSHIFT_EN;
    logic          oFEED_ZERO;
    logic [1:0]    oKERN_OP;
    logic          oCEN_VAL;
    logic [XW-1:0] oX;
    logic [YW-1:0] oY;
    logic          oBORDER;
    logic          oFRAME_DONE;
    logic          oERR;
    logic          oBUSY;

    morph_frame_seq #(
        .IMG_W (W),
        .IMG_H (H),
        .XW    (XW),
        .YW    (YW),
        .NW    (NW)
    ) dut (
        .iclk        (iclk),
        .irst_n      (irst_n),
        .iFVAL       (iFVAL),
        .iDVAL       (iDVAL),
        .iMODE       (iMODE),
        .oSHIFT_EN   (oSHIFT_EN),
        .oFEED_ZERO  (oFEED_ZERO),
        .oKERN_OP    (oKERN_OP),
        .oCEN_VAL    (oCEN_VAL),
        .oX          (oX),
        .oY          (oY),
        .oBORDER     (oBORDER),
        .oFRAME_DONE (oFRAME_DONE),
        .oERR        (oERR),
        .oBUSY       (oBUSY)
    );

    initial iclk = 1'b0;
    always #5 iclk = ~iclk;

    int errors = 0;
    int checks = 0;

    // Reference model state
    bit       m_busy, m_post, m_fprev;
    int       m_pix, m_fl, m_shifts, m_done_cd;
    logic [1:0] m_kern;

    // Per-frame observations
    int n_cen, n_feed, n_border, n_done, n_err, last_x, last_y;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
        end
    endtask

    function automatic logic [1:0] mode_map(input logic [1:0] m);
        return (m == 2'b11) ? 2'b00 : m;
    endfunction

    task automatic model_reset();
        m_busy = 0; m_post = 0; m_fprev = 0;
        m_pix = 0; m_fl = 0; m_shifts = 0; m_done_cd = 0;
        m_kern = 2'b00;
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_shift"}, 32'(oSHIFT_EN), 0);
        chk({tag, "_feed"},  32'(oFEED_ZERO), 0);
        chk({tag, "_kern"},  32'(oKERN_OP), 0);
        chk({tag, "_cen"},   32'(oCEN_VAL), 0);
        chk({tag, "_x"},     32'(oX), 0);
        chk({tag, "_y"},     32'(oY), 0);
        chk({tag, "_border"},32'(oBORDER), 0);
        chk({tag, "_done"},  32'(oFRAME_DONE), 0);
        chk({tag, "_err"},   32'(oERR), 0);
        chk({tag, "_busy"},  32'(oBUSY), 0);
    endtask

    // One clock cycle: drive, check combinational outputs, clock, check registered outputs.
    task automatic cyc(input logic fv, input logic dv);
        bit start, acc, flushing, eshift, e_err, e_cen, e_done;
        int o;
        iFVAL = fv;
        iDVAL = dv;
        #1;
        start    = !m_busy && !m_post && fv && !m_fprev;
        acc      = fv && dv && ((m_busy && m_pix < N) || start);
        flushing = m_busy && (m_pix == N);
        eshift   = acc || flushing;
        chk("shift_en", 32'(oSHIFT_EN), 32'(eshift));
        chk("feed_zero", 32'(oFEED_ZERO), 32'(flushing));
        chk("busy_pre", 32'(oBUSY), 32'(m_busy));
        if (oFEED_ZERO) n_feed++;

        @(posedge iclk);
        #1;
        e_err  = (m_busy && m_pix < N && !fv) || ((flushing || m_post) && fv && dv);
        e_done = (m_done_cd == 1);
        if (m_done_cd > 0) m_done_cd--;
        e_cen = 0;
        o = 0;
        if (start) begin
            m_shifts = 0; m_pix = 0; m_fl = 0;
            m_busy = 1;
            m_kern = mode_map(iMODE);
        end
        if (eshift) begin
            if (m_shifts >= P) begin
                e_cen = 1;
                o = m_shifts - P;
            end
            m_shifts++;
        end
        if (m_post && !fv) m_post = 0;
        if (m_busy && !start && m_pix < N && !fv) begin
            m_busy = 0;
        end else begin
            if (acc) m_pix++;
            if (flushing) begin
                m_fl++;
                if (m_fl == P) begin
                    m_busy = 0; m_post = 1; m_done_cd = 1;
                end
            end
        end
        m_fprev = fv;

        chk("cen_val", 32'(oCEN_VAL), 32'(e_cen));
        if (e_cen) begin
            chk("cen_x", 32'(oX), 32'(o % W));
            chk("cen_y", 32'(oY), 32'(o / W));
        end
        chk("border", 32'(oBORDER),
            32'(e_cen && ((o % W) == 0 || (o % W) == W-1 || (o / W) == 0 || (o / W) == H-1)));
        chk("err", 32'(oERR), 32'(e_err));
        chk("frame_done", 32'(oFRAME_DONE), 32'(e_done));
        chk("kern_op", 32'(oKERN_OP), 32'(m_kern));
        chk("busy_post", 32'(oBUSY), 32'(m_busy));

        if (oCEN_VAL) begin
            n_cen++;
            last_x = int'(oX);
            last_y = int'(oY);
            if (oBORDER) n_border++;
        end
        if (oFRAME_DONE) n_done++;
        if (oERR) n_err++;
    endtask

    // One frame: optional random iDVAL duty, abort, stray pixel in flush, reset in flush.
    task automatic run_frame(input logic [1:0] mode, input logic [1:0] mode_mid, input bit rnd,
                             input int abort_at, input int poke_at, input int rst_at);
        int  guard;
        bit  aborted, was_reset;
        logic dv;
        aborted = 0; was_reset = 0;
        n_cen = 0; n_feed = 0; n_border = 0; n_done = 0; n_err = 0; last_x = -1; last_y = -1;
        iMODE = mode;
        cyc(1'b1, 1'b0);
        guard = 0;
        while (m_pix < N && guard < 2000) begin
            guard++;
            if (m_pix == abort_at) begin
                cyc(1'b0, 1'b0);
                aborted = 1;
                break;
            end
            if (m_pix == N / 2) iMODE = mode_mid;
            dv = rnd ? ($urandom_range(0, 1) == 1) : 1'b1;
            cyc(1'b1, dv);
        end
        chk("pixel_budget", 32'(guard < 2000), 1);
        if (!aborted) begin
            guard = 0;
            while (m_busy && guard < 50) begin
                guard++;
                if (m_fl == rst_at) begin
                    irst_n = 1'b0; iFVAL = 1'b0; iDVAL = 1'b0;
                    #1;
                    chk_all_zero("rst_flush");
                    model_reset();
                    @(posedge iclk);
                    #1;
                    chk("rst_flush_err_hold", 32'(oERR), 0);
                    irst_n = 1'b1;
                    was_reset = 1;
                    break;
                end
                cyc(1'b1, (m_fl == poke_at));
            end
            chk("flush_budget", 32'(guard < 50), 1);
            if (!was_reset) begin
                cyc(1'b1, 1'b0);
                cyc(1'b1, 1'b0);
            end
        end
        cyc(1'b0, 1'b0);
        cyc(1'b0, 1'b0);

        if (was_reset) begin
            chk("rst_frame_err", 32'(n_err), 0);
            chk("rst_frame_done", 32'(n_done), 0);
        end else if (aborted) begin
            chk("abort_err", 32'(n_err), 1);
            chk("abort_feed", 32'(n_feed), 0);
            chk("abort_done", 32'(n_done), 0);
            chk("abort_cen", 32'(n_cen), 32'((abort_at > P) ? abort_at - P : 0));
        end else begin
            chk("frame_cen_count", 32'(n_cen), N);
            chk("frame_last_x", 32'(last_x), W - 1);
            chk("frame_last_y", 32'(last_y), H - 1);
            chk("frame_feed_cycles", 32'(n_feed), P);
            chk("frame_done_count", 32'(n_done), 1);
            chk("frame_border_count", 32'(n_border), 2*W + 2*H - 4);
            chk("frame_err_count", 32'(n_err), 32'(poke_at >= 0));
            chk("frame_kern", 32'(oKERN_OP), 32'(mode_map(mode)));
        end
    endtask

    initial begin
        irst_n = 1'b0;
        iFVAL  = 1'b0;
        iDVAL  = 1'b0;
        iMODE  = 2'b00;
        model_reset();
        #2;
        chk_all_zero("reset");
        @(posedge iclk);
        #1;
        irst_n = 1'b1;

        // Back-to-back pixels, dilate
        run_frame(2'b01, 2'b01, 1'b0, -1, -1, -1);
        // Random 50% iDVAL duty
        run_frame(2'b01, 2'b01, 1'b1, -1, -1, -1);
        // iFVAL dropped after 20 pixels, then a clean frame
        run_frame(2'b01, 2'b01, 1'b0, 20, -1, -1);
        run_frame(2'b01, 2'b01, 1'b0, -1, -1, -1);
        // iMODE changed mid-frame, then the new mode and the reserved code
        run_frame(2'b01, 2'b10, 1'b1, -1, -1, -1);
        run_frame(2'b10, 2'b10, 1'b0, -1, -1, -1);
        run_frame(2'b11, 2'b11, 1'b0, -1, -1, -1);
        // Stray pixel during flush
        run_frame(2'b01, 2'b01, 1'b0, -1, 3, -1);
        // Reset pulse during flush, then recovery
        run_frame(2'b10, 2'b10, 1'b0, -1, -1, 4);
        run_frame(2'b01, 2'b01, 1'b1, -1, -1, -1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
